sipo_deserializer: RTL and testbench
====================================

SIPO_DESERIALIZER -- requirements
Module: sipo_deserializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: parallel word width, legal range 2..64.
REQ-002 SHALL have parameter LSB_FIRST, default 0: 0 = first received bit lands in data_out[DATA_WIDTH-1]; 1 = first bit lands in data_out[0].
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port data_in  input  1  serial data bit.
REQ-006 SHALL have port in_valid  input  1  data_in carries a bit this cycle.
REQ-007 SHALL have port in_ready  output  1  block accepts a bit this cycle.
REQ-008 SHALL have port flush  input  1  discard any partial or stalled frame.
REQ-009 SHALL have port data_out  output  DATA_WIDTH  assembled parallel word.
REQ-010 SHALL have port out_valid  output  1  data_out holds an unconsumed word.
REQ-011 SHALL have port out_ready  input  1  consumer takes data_out this cycle.
REQ-012 SHALL have port bit_count  output  $clog2(DATA_WIDTH+2)  bits accepted in the current frame.
REQ-013 SHALL have port parity_err  output  1  parity flag for data_out, qualified by out_valid.

Function
REQ-014 A bit SHALL be accepted on a rising edge where in_valid && in_ready && !flush; bit_count increments by 1.
REQ-015 Frame length SHALL be DATA_WIDTH bits (DATA_WIDTH+1 with parity, see Configuration).
REQ-016 FSM states SHALL be IDLE (bit_count=0), SHIFT (partial frame), STALL (full frame held, output busy).
REQ-017 IDLE->SHIFT on first accepted bit; SHIFT->IDLE on last accepted bit when output register free (!out_valid, or out_valid && out_ready same cycle); SHIFT->STALL on last accepted bit otherwise.
REQ-018 On the last-bit edge with output free, data_out SHALL load the assembled word and out_valid SHALL be 1 from the next cycle (1-cycle latency); bit_count returns to 0.
REQ-019 in_ready SHALL be 1 in IDLE and SHIFT, 0 in STALL; combinational from state only.
REQ-020 STALL->IDLE on edge where out_ready: held word loads into data_out, out_valid stays 1, bit_count=0.
REQ-021 out_valid SHALL remain 1 and data_out stable until out_ready; out_valid clears on out_ready edge unless a new word loads the same edge.
REQ-022 flush SHALL clear the shift register and bit_count, go to IDLE, and win over a simultaneous bit acceptance; data_out/out_valid unaffected.
REQ-023 flush in STALL SHALL discard the held word; no word emitted.
REQ-024 in_valid=0 mid-frame SHALL hold state indefinitely (no timeout).

Reset
REQ-025 On reset edge: state IDLE, bit_count=0, shift register 0, data_out=0, out_valid=0, parity_err=0; in_ready=1 the following cycle.
REQ-026 reset SHALL override flush, in_valid and out_ready; partial frames and any held/output word are lost.

Configuration
REQ-027 Macro SIPO_PARITY_EN: when defined, frame = DATA_WIDTH data bits + 1 even-parity bit; parity bit not stored in data_out; parity_err = XOR of all DATA_WIDTH+1 bits, registered with data_out.
REQ-028 When SIPO_PARITY_EN is undefined, frame = DATA_WIDTH bits and parity_err SHALL be constant 0; port list unchanged.

Structure
REQ-029 Package sipo_pkg SHALL hold the state enum (IDLE, SHIFT, STALL) and default-width constants.
REQ-030 Bit counter with terminal-count flag SHALL be sub-module sipo_bit_counter; shift/assembly, FSM and output register remain in sipo_deserializer.

Verification (DATA_WIDTH=8)
REQ-031 LSB_FIRST=0, out_ready=1, bits 1,0,1,0,1,1,0,1 consecutive -> data_out=8'hAD, out_valid=1 for exactly one cycle, starting cycle after 8th bit.
REQ-032 LSB_FIRST=1, same bits -> data_out=8'hB5.
REQ-033 out_ready=0, two frames 8'hAD then 8'h3C -> after 2nd frame in_ready=0 (STALL), data_out=8'hAD; assert out_ready 1 cycle -> data_out=8'h3C, out_valid=1, in_ready=1.
REQ-034 flush after 5 bits, then 8 bits 8'hFF -> data_out=8'hFF, no word from the partial frame; flush coincident with 8th bit -> no word, bit_count=0.
REQ-035 reset asserted after 3 bits with out_valid=1 -> next cycle out_valid=0, data_out=0, bit_count=0, in_ready=1.
REQ-036 SIPO_PARITY_EN: 8'hAD + parity 1 -> parity_err=0; 8'hAD + parity 0 -> parity_err=1, data_out=8'hAD both cases.

Source files
------------

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared state type and default constants for the SIPO deserializer.
// Optional feature: define SIPO_PARITY_EN to append one even-parity bit to each frame.
package sipo_pkg;

  localparam int unsigned DefaultDataWidth = 8;
  localparam int unsigned DefaultLsbFirst  = 0;

`ifdef SIPO_PARITY_EN
  localparam int unsigned ParityBits = 1;
`else
  localparam int unsigned ParityBits = 0;
`endif

  // Idle (no bits yet), shift (partial frame), stall (full frame waiting for output register)
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StStall = 2'd2
  } sipo_state_e;

  // Serial bits per frame for a given parallel width
  function automatic int unsigned frame_len(int unsigned data_width);
    return data_width + ParityBits;
  endfunction

endpackage

// File: rtl/sipo_bit_counter.sv
// sipo_bit_counter: per-frame accepted-bit counter with terminal-count flag.
// Clear wins over increment; last_o flags the final bit position of a frame.
module sipo_bit_counter #(
  parameter int unsigned FrameLen = 8,
  parameter int unsigned CntW     = 4
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            clr_i,
  input  logic            inc_i,
  output logic [CntW-1:0] count_o,
  output logic            last_o
);

  logic [CntW-1:0] count_d, count_q;

  // Next count: clear, step on an accepted bit, or hold
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign last_o  = (count_q == CntW'(FrameLen - 1));

endmodule

// File: rtl/sipo_deserializer.sv
// sipo_deserializer: serial-in parallel-out deserializer with valid/ready on both sides.
// A full frame that cannot enter a busy output register is held until the consumer drains it.
// Optional feature: define SIPO_PARITY_EN for an extra even-parity bit per frame.
module sipo_deserializer
  import sipo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned LSB_FIRST  = DefaultLsbFirst
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            data_in,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            flush,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(DATA_WIDTH+2)-1:0] bit_count,
  output logic                            parity_err
);

  localparam int unsigned FrameLen = frame_len(DATA_WIDTH);
  localparam int unsigned CntW     = $clog2(DATA_WIDTH + 2);

  sipo_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] sreg_q, sreg_shift, data_out_q;
  logic                  out_valid_q;
  logic                  accept, cnt_last, out_free;
  logic                  load_frame, load_held, cnt_clr;

  sipo_bit_counter #(
    .FrameLen (FrameLen),
    .CntW     (CntW)
  ) u_bit_counter (
    .clk_i   (clk),
    .reset_i (reset),
    .clr_i   (cnt_clr),
    .inc_i   (accept),
    .count_o (bit_count),
    .last_o  (cnt_last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; flush always returns to idle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StShift;
      StShift: if (accept && cnt_last) state_d = out_free ? StIdle : StStall;
      StStall: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) begin
      state_d = StIdle;
    end
  end

  // FSM outputs and datapath strobes
  always_comb begin
    in_ready   = (state_q != StStall);
    accept     = in_valid && in_ready && !flush;
    out_free   = !out_valid_q || out_ready;
    load_frame = accept && cnt_last && out_free;
    load_held  = (state_q == StStall) && out_ready && !flush;
    cnt_clr    = flush || load_frame || load_held;
  end

  // Shifted word; the trailing parity bit is never stored
  always_comb begin
    sreg_shift = sreg_q;
    if (bit_count < CntW'(DATA_WIDTH)) begin
      if (LSB_FIRST != 0) begin
        sreg_shift = {data_in, sreg_q[DATA_WIDTH-1:1]};
      end else begin
        sreg_shift = {sreg_q[DATA_WIDTH-2:0], data_in};
      end
    end
  end

  // Shift register; also holds the complete word while stalled
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      sreg_q <= '0;
    end else if (accept) begin
      sreg_q <= sreg_shift;
    end
  end

  // Output register; a new load keeps out_valid high across a consume
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else if (load_frame) begin
      data_out_q  <= sreg_shift;
      out_valid_q <= 1'b1;
    end else if (load_held) begin
      data_out_q  <= sreg_q;
      out_valid_q <= 1'b1;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign data_out  = data_out_q;
  assign out_valid = out_valid_q;

`ifdef SIPO_PARITY_EN
  logic par_q, perr_q;

  // Running XOR over every bit of the frame, parity bit included
  always_ff @(posedge clk) begin
    if (reset || cnt_clr) begin
      par_q <= 1'b0;
    end else if (accept) begin
      par_q <= par_q ^ data_in;
    end
  end

  // Parity flag loads alongside data_out
  always_ff @(posedge clk) begin
    if (reset) begin
      perr_q <= 1'b0;
    end else if (load_frame) begin
      perr_q <= par_q ^ data_in;
    end else if (load_held) begin
      perr_q <= par_q;
    end
  end

  assign parity_err = perr_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_sipo_deserializer.sv
// Scoreboard bench: MSB-first and LSB-first instances share one stimulus stream.
module tb_sipo_deserializer;

  localparam int unsigned W = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned Frame = W + 1;
`else
  localparam int unsigned Frame = W;
`endif
  localparam int unsigned CntW = $clog2(W + 2);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic data_in = 1'b0;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b0;

  logic            in_ready_m, in_ready_l, out_valid_m, out_valid_l, perr_m, perr_l;
  logic [W-1:0]    data_out_m, data_out_l;
  logic [CntW-1:0] bc_m, bc_l;

  always #5 clk = ~clk;

  sipo_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(0)) u_msb (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready_m),
    .flush(flush), .data_out(data_out_m), .out_valid(out_valid_m), .out_ready(out_ready),
    .bit_count(bc_m), .parity_err(perr_m)
  );

  sipo_deserializer #(.DATA_WIDTH(W), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .reset(reset), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready_l),
    .flush(flush), .data_out(data_out_l), .out_valid(out_valid_l), .out_ready(out_ready),
    .bit_count(bc_l), .parity_err(perr_l)
  );

  typedef struct {
    logic [W-1:0] msb;
    logic [W-1:0] lsb;
    logic         par;
  } exp_t;

  exp_t exp_q[$];
  bit   frame_bits[$];
  bit   m_busy = 1'b0;
  bit   m_held = 1'b0;
  exp_t held_word;
  int   errors = 0;
  int   checks = 0;
  bit   started = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference word from the collected bit list: bit i is the i-th bit received
  function automatic exp_t assemble();
    exp_t e;
    e.msb = '0;
    e.lsb = '0;
    e.par = 1'b0;
    for (int i = 0; i < int'(W); i++) begin
      if (frame_bits[i]) begin
        e.msb[W-1-i] = 1'b1;
        e.lsb[i]     = 1'b1;
      end
    end
`ifdef SIPO_PARITY_EN
    for (int i = 0; i < int'(Frame); i++) e.par = e.par ^ frame_bits[i];
`endif
    return e;
  endfunction

  // Behavioural model: bit list, one-deep output slot, one held word
  always @(posedge clk) begin : model
    bit   emit;
    exp_t e;
    emit = 1'b0;
    if (reset) begin
      frame_bits.delete();
      exp_q.delete();
      m_busy = 1'b0;
      m_held = 1'b0;
    end else begin
      if (m_held) begin
        if (flush) m_held = 1'b0;
        else if (out_ready) begin
          e = held_word;
          emit = 1'b1;
          m_held = 1'b0;
        end
      end else if (flush) begin
        frame_bits.delete();
      end else if (in_valid) begin
        frame_bits.push_back(data_in);
        if (frame_bits.size() == int'(Frame)) begin
          e = assemble();
          frame_bits.delete();
          if (!m_busy || out_ready) emit = 1'b1;
          else begin
            held_word = e;
            m_held = 1'b1;
          end
        end
      end
      if (emit) begin
        exp_q.push_back(e);
        m_busy = 1'b1;
      end else if (out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Status checker: handshake and counter outputs every cycle
  always @(negedge clk) begin
    if (started) begin
      chk("in_ready", in_ready_m, !m_held);
      chk("lsb_in_ready", in_ready_l, !m_held);
      chk("out_valid", out_valid_m, m_busy);
      chk("lsb_out_valid", out_valid_l, m_busy);
      chk("bit_count", bc_m, m_held ? Frame : frame_bits.size());
      chk("lsb_bit_count", bc_l, m_held ? Frame : frame_bits.size());
    end
  end

  // Monitor: compare each consumed word with the scoreboard head
  always @(negedge clk) begin : monitor
    exp_t e;
    if (started && out_valid_m && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_word: got %0h expected no word", data_out_m);
      end else begin
        e = exp_q.pop_front();
        chk("word_msb", data_out_m, e.msb);
        chk("word_lsb", data_out_l, e.lsb);
        chk("parity_msb", perr_m, e.par);
        chk("parity_lsb", perr_l, e.par);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // First n bits of w, MSB first, back to back
  task automatic send_bits(input logic [W-1:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      data_in  = w[W-1-i];
      step();
    end
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input bit par_ok);
    send_bits(w, W);
`ifdef SIPO_PARITY_EN
    in_valid = 1'b1;
    data_in  = (^w) ^ !par_ok;
    step();
    in_valid = 1'b0;
`endif
  endtask

  initial begin
    reset = 1'b1;
    step();
    started = 1'b1;
    @(negedge clk);
    chk("reset_out_valid", out_valid_m, 0);
    chk("reset_data_out", data_out_m, 0);
    chk("reset_bit_count", bc_m, 0);
    chk("reset_in_ready", in_ready_m, 1);
    chk("reset_parity", perr_m, 0);
    step();
    reset = 1'b0;

    // Single frame, consumer always ready
    out_ready = 1'b1;
    send_frame(8'hAD, 1'b1);
    @(negedge clk);
    chk("msb_first_AD", data_out_m, 8'hAD);
    chk("lsb_first_B5", data_out_l, 8'hB5);
    chk("one_cycle_valid_hi", out_valid_m, 1);
    step();
    @(negedge clk);
    chk("one_cycle_valid_lo", out_valid_m, 0);

    // Back-pressure: second frame stalls behind the first
    out_ready = 1'b0;
    step();
    send_frame(8'hAD, 1'b1);
    send_frame(8'h3C, 1'b1);
    @(negedge clk);
    chk("stall_in_ready", in_ready_m, 0);
    chk("stall_data_out", data_out_m, 8'hAD);
    step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    @(negedge clk);
    chk("unstall_data_out", data_out_m, 8'h3C);
    chk("unstall_out_valid", out_valid_m, 1);
    chk("unstall_in_ready", in_ready_m, 1);
    step();
    out_ready = 1'b1;

    // Flush of a partial frame, then a full frame
    send_bits(8'hA5, 5);
    flush = 1'b1;
    in_valid = 1'b1;
    data_in = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_bit_count", bc_m, 0);
    send_frame(8'hFF, 1'b1);
    @(negedge clk);
    chk("after_flush_FF", data_out_m, 8'hFF);
    step();
    // Flush coincident with the final data bit
    send_bits(8'h5A, W - 1);
    in_valid = 1'b1;
    data_in = 1'b0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_last_no_word", out_valid_m, 0);
    chk("flush_last_count", bc_m, 0);

    // Reset with a word pending and a partial frame
    out_ready = 1'b0;
    step();
    send_frame(8'hAD, 1'b1);
    send_bits(8'hE0, 3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid_m, 0);
    chk("rst_data_out", data_out_m, 0);
    chk("rst_bit_count", bc_m, 0);
    chk("rst_in_ready", in_ready_m, 1);

`ifdef SIPO_PARITY_EN
    out_ready = 1'b1;
    step();
    send_frame(8'hAD, 1'b1);
    @(negedge clk);
    chk("parity_good_flag", perr_m, 0);
    chk("parity_good_data", data_out_m, 8'hAD);
    step();
    send_frame(8'hAD, 1'b0);
    @(negedge clk);
    chk("parity_bad_flag", perr_m, 1);
    chk("parity_bad_data", data_out_m, 8'hAD);
    step();
`endif

    // Randomized traffic with varying consumer back-pressure
    for (int phase = 0; phase < 6; phase++) begin
      for (int n = 0; n < 500; n++) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        data_in   = 1'($urandom);
        flush     = ($urandom_range(0, 63) == 0);
        reset     = ($urandom_range(0, 499) == 0);
        out_ready = ($urandom_range(0, 3) < (phase % 3) + 1);
        step();
      end
    end

    in_valid = 1'b0;
    flush = 1'b0;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
